// File: rtl/tucanos_process_scheduler_pkg.sv
// Shared codes for the round-robin process scheduler: slot status, switch cause, FSM state.
package tucanos_sched_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_READY   = 2'd1,
        SLOT_WAITING = 2'd2,
        SLOT_HALTED  = 2'd3
    } slot_status_e;

    typedef enum logic [1:0] {
        CAUSE_QUANTUM  = 2'd0,
        CAUSE_WAIT     = 2'd1,
        CAUSE_HALT     = 2'd2,
        CAUSE_RESERVED = 2'd3
    } switch_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAVE     = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_DISPATCH = 3'd3,
        ST_STALL    = 3'd4
    } sched_state_e;

    // The reserved cause code behaves like a quantum expiry.
    function automatic slot_status_e cause_to_status(input logic [1:0] cause);
        case (cause)
            CAUSE_WAIT: return SLOT_WAITING;
            CAUSE_HALT: return SLOT_HALTED;
            default:    return SLOT_READY;
        endcase
    endfunction

endpackage

// File: rtl/tucanos_process_scheduler_if.sv
// Request/dispatch bundle between the OS context switcher and the scheduler.
// Optional TUCANOS_SCHED_STATS_EN adds the dispatch-counter read port.
interface tucanos_process_scheduler_if #(
    parameter int PC_WIDTH    = 12,
    parameter int INDEX_WIDTH = 2
);
    logic                   switch_request;
    logic [1:0]             switch_cause;
    logic [PC_WIDTH-1:0]    current_pc;
    logic                   create_valid;
    logic [INDEX_WIDTH-1:0] create_index;
    logic [PC_WIDTH-1:0]    create_pc;
    logic                   io_done;
    logic [INDEX_WIDTH-1:0] io_index;
    logic                   next_valid;
    logic [INDEX_WIDTH-1:0] next_index;
    logic [PC_WIDTH-1:0]    next_pc;
    logic [INDEX_WIDTH-1:0] current_index;
    logic                   busy;
    logic                   all_halted;
`ifdef TUCANOS_SCHED_STATS_EN
    logic [INDEX_WIDTH-1:0] stats_index;
    logic [7:0]             stats_count;
`endif

    modport master (
        output switch_request, switch_cause, current_pc,
        output create_valid, create_index, create_pc,
        output io_done, io_index,
`ifdef TUCANOS_SCHED_STATS_EN
        output stats_index,
        input  stats_count,
`endif
        input  next_valid, next_index, next_pc, current_index, busy, all_halted
    );

    modport slave (
        input  switch_request, switch_cause, current_pc,
        input  create_valid, create_index, create_pc,
        input  io_done, io_index,
`ifdef TUCANOS_SCHED_STATS_EN
        input  stats_index,
        output stats_count,
`endif
        output next_valid, next_index, next_pc, current_index, busy, all_halted
    );

endinterface

// File: rtl/tucanos_process_scheduler_slot.sv
// One process slot: status and saved PC, updated with create > save > io_done priority.
module tucanos_sched_slot
    import tucanos_sched_pkg::*;
#(
    parameter int PC_WIDTH = 12
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                create_en,
    input  logic [PC_WIDTH-1:0] create_pc,
    input  logic                save_en,
    input  slot_status_e        save_status,
    input  logic [PC_WIDTH-1:0] save_pc,
    input  logic                io_done_en,
    output slot_status_e        status,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status <= SLOT_FREE;
            pc     <= '0;
        end else if (create_en && status == SLOT_FREE) begin
            status <= SLOT_READY;
            pc     <= create_pc;
        end else if (save_en) begin
            pc <= save_pc;
            // An I/O completion landing on the save cycle wins over the new WAIT.
            if (io_done_en && save_status == SLOT_WAITING) status <= SLOT_READY;
            else                                           status <= save_status;
        end else if (io_done_en && status == SLOT_WAITING) begin
            status <= SLOT_READY;
        end
    end

endmodule

// File: rtl/tucanos_process_scheduler.sv
// Round-robin process scheduler: saves the outgoing PC, scans for the next READY slot, dispatches it.
// Optional TUCANOS_SCHED_STATS_EN adds per-slot 8-bit saturating dispatch counters.
//
//   state    | meaning
//   IDLE     | waiting for a switch request
//   SAVE     | write back the outgoing slot (no write when current_index is 0)
//   SEARCH   | probe one slot per cycle for READY
//   DISPATCH | next_valid pulse, current_index takes the new process
//   STALL    | nothing READY; wait for an io_done to wake a slot
module tucanos_process_scheduler
    import tucanos_sched_pkg::*;
#(
    parameter int NUM_PROCS   = 3,
    parameter int PC_WIDTH    = 12,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    tucanos_process_scheduler_if.slave bus
);

    localparam int                     NUM_SLOTS = 2 ** INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_SLOT = INDEX_WIDTH'(NUM_PROCS);

    sched_state_e           state;
    logic [INDEX_WIDTH-1:0] ptr;
    logic [INDEX_WIDTH-1:0] probes;
    logic [PC_WIDTH-1:0]    cap_pc;
    logic [1:0]             cap_cause;
    logic                   next_valid_r;
    logic [INDEX_WIDTH-1:0] next_index_r;
    logic [PC_WIDTH-1:0]    next_pc_r;
    logic [INDEX_WIDTH-1:0] cur_index_r;
    logic                   busy_r;
    slot_status_e           save_status;
    slot_status_e           slot_status [NUM_SLOTS];
    logic [PC_WIDTH-1:0]    slot_pc     [NUM_SLOTS];
    logic                   io_wake;
    logic                   any_halted;
    logic                   any_live;

    function automatic logic [INDEX_WIDTH-1:0] next_slot(input logic [INDEX_WIDTH-1:0] idx);
        return (idx >= LAST_SLOT) ? INDEX_WIDTH'(1) : idx + INDEX_WIDTH'(1);
    endfunction

    assign save_status = cause_to_status(cap_cause);

    // Index 0 and indices beyond NUM_PROCS read as permanently FREE.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        if (i >= 1 && i <= NUM_PROCS) begin : g_real
            tucanos_sched_slot #(.PC_WIDTH(PC_WIDTH)) u_slot (
                .clock       (clock),
                .reset_n     (reset_n),
                .create_en   (bus.create_valid && bus.create_index == INDEX_WIDTH'(i)),
                .create_pc   (bus.create_pc),
                .save_en     (state == ST_SAVE && cur_index_r == INDEX_WIDTH'(i)),
                .save_status (save_status),
                .save_pc     (cap_pc),
                .io_done_en  (bus.io_done && bus.io_index == INDEX_WIDTH'(i)),
                .status      (slot_status[i]),
                .pc          (slot_pc[i])
            );
        end else begin : g_tie
            assign slot_status[i] = SLOT_FREE;
            assign slot_pc[i]     = '0;
        end
    end

    assign io_wake = bus.io_done && slot_status[bus.io_index] == SLOT_WAITING;

    always_comb begin
        any_halted = 1'b0;
        any_live   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_status[i] == SLOT_HALTED)   any_halted = 1'b1;
            else if (slot_status[i] != SLOT_FREE) any_live  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            probes       <= '0;
            cap_pc       <= '0;
            cap_cause    <= '0;
            next_valid_r <= 1'b0;
            next_index_r <= '0;
            next_pc_r    <= '0;
            cur_index_r  <= '0;
            busy_r       <= 1'b0;
        end else begin
            next_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.switch_request) begin
                        cap_pc    <= bus.current_pc;
                        cap_cause <= bus.switch_cause;
                        ptr       <= next_slot(cur_index_r);
                        probes    <= INDEX_WIDTH'(1);
                        busy_r    <= 1'b1;
                        state     <= ST_SAVE;
                    end
                end
                ST_SAVE: state <= ST_SEARCH;
                ST_SEARCH: begin
                    if (slot_status[ptr] == SLOT_READY) begin
                        next_valid_r <= 1'b1;
                        next_index_r <= ptr;
                        next_pc_r    <= slot_pc[ptr];
                        state        <= ST_DISPATCH;
                    end else if (probes == LAST_SLOT) begin
                        cur_index_r <= '0;
                        state       <= ST_STALL;
                    end else begin
                        ptr    <= next_slot(ptr);
                        probes <= probes + INDEX_WIDTH'(1);
                    end
                end
                ST_DISPATCH: begin
                    cur_index_r <= next_index_r;
                    busy_r      <= 1'b0;
                    state       <= ST_IDLE;
                end
                ST_STALL: begin
                    if (io_wake) begin
                        next_valid_r <= 1'b1;
                        next_index_r <= bus.io_index;
                        next_pc_r    <= slot_pc[bus.io_index];
                        state        <= ST_DISPATCH;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.next_valid    = next_valid_r;
    assign bus.next_index    = next_index_r;
    assign bus.next_pc       = next_pc_r;
    assign bus.current_index = cur_index_r;
    assign bus.busy          = busy_r;
    assign bus.all_halted    = any_halted && !any_live;

`ifdef TUCANOS_SCHED_STATS_EN
    logic [7:0] dispatch_count [NUM_SLOTS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) dispatch_count[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (bus.create_valid && bus.create_index == INDEX_WIDTH'(i) &&
                    slot_status[i] == SLOT_FREE)
                    dispatch_count[i] <= '0;
                else if (state == ST_DISPATCH && next_index_r == INDEX_WIDTH'(i) &&
                         dispatch_count[i] != 8'hFF)
                    dispatch_count[i] <= dispatch_count[i] + 8'd1;
            end
        end
    end

    assign bus.stats_count = dispatch_count[bus.stats_index];
`endif

endmodule

// File: tb/tb_tucanos_process_scheduler.sv
// Scoreboard bench for tucanos_process_scheduler: random traffic against a round-robin table model.
module tb_tucanos_process_scheduler;

    localparam int NP  = 3;
    localparam int PCW = 12;
    localparam int IW  = 2;
    localparam int FREE = 0, READY = 1, WAITING = 2, HALTED = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    tucanos_process_scheduler_if #(.PC_WIDTH(PCW), .INDEX_WIDTH(IW)) bus ();

    tucanos_process_scheduler #(.NUM_PROCS(NP), .PC_WIDTH(PCW), .INDEX_WIDTH(IW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct { int idx; int pc; int at; } exp_t;
    exp_t expq[$];

    int m_status [NP+1];
    int m_pc     [NP+1];
    int m_count  [NP+1];
    int m_cur;
    bit m_stalled;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_all_halted();
        int h, live;
        h = 0; live = 0;
        for (int i = 1; i <= NP; i++) begin
            if (m_status[i] == HALTED)    h = 1;
            else if (m_status[i] != FREE) live = 1;
        end
        return (h == 1 && live == 0) ? 1 : 0;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && bus.next_valid) begin
            if (expq.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_dispatch: got index %0d pc %0d, expected no dispatch (cycle %0d)",
                         bus.next_index, bus.next_pc, cyc);
            end else begin
                e = expq.pop_front();
                check("next_index", int'(bus.next_index), e.idx);
                check("next_pc", int'(bus.next_pc), e.pc);
                check("dispatch_cycle", cyc, e.at);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.switch_request = 1'b0;
        bus.switch_cause   = '0;
        bus.current_pc     = '0;
        bus.create_valid   = 1'b0;
        bus.create_index   = '0;
        bus.create_pc      = '0;
        bus.io_done        = 1'b0;
        bus.io_index       = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i <= NP; i++) begin
            m_status[i] = FREE;
            m_pc[i]     = 0;
            m_count[i]  = 0;
        end
        m_cur     = 0;
        m_stalled = 1'b0;
        expq.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic create(input int idx, input int pc);
        bus.create_valid = 1'b1;
        bus.create_index = idx[IW-1:0];
        bus.create_pc    = pc[PCW-1:0];
        if (idx >= 1 && idx <= NP && m_status[idx] == FREE) begin
            m_status[idx] = READY;
            m_pc[idx]     = pc;
            m_count[idx]  = 0;
        end
        tick();
        bus.create_valid = 1'b0;
    endtask

    task automatic recreate();
        for (int i = 1; i <= NP; i++) create(i, int'($urandom_range(0, 4095)));
    endtask

    task automatic idle_io(input int idx);
        bus.io_done  = 1'b1;
        bus.io_index = idx[IW-1:0];
        if (idx >= 1 && idx <= NP && m_status[idx] == WAITING) m_status[idx] = READY;
        tick();
        bus.io_done = 1'b0;
    endtask

    task automatic expect_dispatch(input int idx, input int at);
        expq.push_back('{idx: idx, pc: m_pc[idx], at: at});
        m_cur     = idx;
        m_stalled = 1'b0;
        if (m_count[idx] < 255) m_count[idx]++;
    endtask

    // Leaving process saves first, then the table is scanned from the slot after it, itself last.
    task automatic switch_req(input int cause, input int pc, input bit collide);
        int n, old, idx;
        n   = cyc;
        old = m_cur;
        bus.switch_request = 1'b1;
        bus.switch_cause   = cause[1:0];
        bus.current_pc     = pc[PCW-1:0];
        if (old != 0) begin
            m_pc[old] = pc;
            if (cause == 1)      m_status[old] = collide ? READY : WAITING;
            else if (cause == 2) m_status[old] = HALTED;
            else                 m_status[old] = READY;
        end
        m_stalled = 1'b1;
        for (int k = 1; k <= NP; k++) begin
            idx = (old + k - 1) % NP + 1;
            if (m_stalled && m_status[idx] == READY) expect_dispatch(idx, n + 2 + k);
        end
        if (m_stalled) m_cur = 0;
        tick();
        bus.switch_request = 1'b0;
        if (collide) begin
            bus.io_done  = 1'b1;
            bus.io_index = old[IW-1:0];
            tick();
            bus.io_done = 1'b0;
        end
    endtask

    task automatic stall_io(input int idx);
        int m;
        m = cyc;
        bus.io_done  = 1'b1;
        bus.io_index = idx[IW-1:0];
        if (idx >= 1 && idx <= NP && m_status[idx] == WAITING) begin
            m_status[idx] = READY;
            expect_dispatch(idx, m + 1);
        end
        tick();
        bus.io_done = 1'b0;
        tick();
    endtask

    function automatic int pick_waiting();
        int q[$];
        for (int i = 1; i <= NP; i++) if (m_status[i] == WAITING) q.push_back(i);
        if (q.size() == 0) return -1;
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    task automatic handle_stall(input int first_io);
        int w;
        repeat (NP + 3) tick();
        check("stall_busy", int'(bus.busy), 1);
        check("stall_current_index", int'(bus.current_index), 0);
        check("stall_all_halted", int'(bus.all_halted), model_all_halted());
        if (first_io >= 0) stall_io(first_io);
        if (m_stalled) begin
            w = pick_waiting();
            if (w > 0) stall_io(w);
            else begin
                do_reset();
                recreate();
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((bus.busy || expq.size() != 0) && t < 60) begin
            tick();
            t++;
        end
        if (t >= 60) begin
            vectors++;
            errors++;
            $display("FAIL wait_idle: busy %0d, %0d dispatches pending after 60 cycles, expected idle",
                     bus.busy, expq.size());
            do_reset();
        end
    endtask

    task automatic check_idle();
`ifdef TUCANOS_SCHED_STATS_EN
        int s;
`endif
        check("current_index", int'(bus.current_index), m_cur);
        check("all_halted", int'(bus.all_halted), model_all_halted());
        check("busy_idle", int'(bus.busy), 0);
`ifdef TUCANOS_SCHED_STATS_EN
        s = int'($urandom_range(0, NP));
        bus.stats_index = s[IW-1:0];
        #1;
        check("stats_count", int'(bus.stats_count), m_count[s]);
`endif
    endtask

    task automatic check_reset_outputs();
        check("rst_next_valid", int'(bus.next_valid), 0);
        check("rst_next_index", int'(bus.next_index), 0);
        check("rst_next_pc", int'(bus.next_pc), 0);
        check("rst_current_index", int'(bus.current_index), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_all_halted", int'(bus.all_halted), 0);
`ifdef TUCANOS_SCHED_STATS_EN
        for (int i = 0; i <= NP; i++) begin
            bus.stats_index = i[IW-1:0];
            #1;
            check("rst_stats_count", int'(bus.stats_count), 0);
        end
`endif
    endtask

    task automatic step(input int cause, input int pc, input bit collide, input int first_io);
        switch_req(cause, pc, collide);
        if (m_stalled) handle_stall(first_io);
        wait_idle();
        check_idle();
    endtask

    initial begin
        idle_inputs();
`ifdef TUCANOS_SCHED_STATS_EN
        bus.stats_index = '0;
`endif
        model_clear();
        repeat (3) tick();
        check_reset_outputs();
        reset_n = 1'b1;
        tick();

        create(1, 10);
        create(2, 20);
        create(3, 30);
        step(0, 0, 1'b0, -1);
        step(0, 14, 1'b0, -1);
        step(0, 22, 1'b0, -1);
        step(0, 33, 1'b0, -1);

        step(2, 15, 1'b0, -1);
        step(0, 21, 1'b0, -1);
        step(2, 31, 1'b0, -1);
        step(1, 25, 1'b0, 2);

        step(2, 26, 1'b0, 1);

        step(0, 0, 1'b0, -1);
        step(0, 40, 1'b0, -1);
        step(1, 77, 1'b1, -1);
        create(2, 99);
        wait_idle();
        check_idle();

        for (int it = 0; it < 250; it++) begin
            int r, cause, fio;
            bit col;
            r = int'($urandom_range(0, 9));
            if (r < 2) create(int'($urandom_range(0, NP)), int'($urandom_range(0, 4095)));
            else if (r == 2) idle_io(int'($urandom_range(0, NP)));
            else begin
                cause = int'($urandom_range(0, 3));
                col   = (m_cur != 0 && cause == 1 && $urandom_range(0, 1) == 1);
                fio   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NP)) : -1;
                step(cause, int'($urandom_range(0, 4095)), col, fio);
            end
            wait_idle();
            check_idle();
        end

        // Reset in the middle of a search must not leak a dispatch pulse.
        wait_idle();
        bus.switch_request = 1'b1;
        bus.switch_cause   = 2'd0;
        bus.current_pc     = 12'h5A5;
        tick();
        bus.switch_request = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        check_reset_outputs();
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check_reset_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
